// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the pipelined LEGv8 core.
// Owns the PC, drives the instruction-memory address and loads the IF/ID
// pipeline register. Handles hazard stalls, branch-redirect flushes, a
// multi-cycle instruction memory, and halts on a misaligned redirect target.
//
// Ports:
//   CLOCK            in   rising-edge clock
//   RESET            in   asynchronous active-high reset
//   imem_addr        out  fetch address (PC register)
//   imem_instr       in   instruction word at imem_addr
//   imem_ready       in   imem_instr valid this cycle
//   stall            in   hold PC and IF/ID
//   redirect         in   taken branch: flush IF/ID and jump
//   redirect_target  in   new PC when redirect=1
//   ifid_pc          out  PC of instruction in IF/ID
//   ifid_instr       out  instruction in IF/ID (NOP_INSTR when invalid)
//   ifid_valid       out  IF/ID holds a real instruction
//   fetch_fault      out  sticky misaligned-redirect flag
//   fetch_count      out  instructions loaded into IF/ID (wraps)
module if_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // State and datapath registers
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            fault_q      <= fault_d;
            count_q      <= count_d;
        end
    end

    // Next-state and next-register logic; priority redirect > stall > !ready > advance
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        fault_d      = fault_q;
        count_d      = count_q;

        case (state_q)
            ST_BOOT: begin
                // One idle cycle after reset; IF/ID stays a bubble
                state_d      = ST_RUN;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
            ST_RUN: begin
                if (redirect) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                    if (redirect_target[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (stall) begin
                    // Hold everything exactly
                    pc_d = pc_q;
                end else if (!imem_ready) begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end else begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_instr;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + PC_W'(4);
                    count_d      = count_q + CNT_W'(1);
                end
            end
            default: begin
                // Fault (or illegal encoding): frozen bubble until reset
                state_d      = ST_FAULT;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_fault = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: table of per-edge vectors plus
// hand-written reset/boot and async-reset-during-fault sequences.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_target;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    if_fetch_stage dut (
        .CLOCK           (CLOCK),
        .RESET           (RESET),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .imem_ready      (imem_ready),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .ifid_pc         (ifid_pc),
        .ifid_instr      (ifid_instr),
        .ifid_valid      (ifid_valid),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count)
    );

    always #5 CLOCK = ~CLOCK;

    // Instruction memory model: word tagged with its own address
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    typedef struct {
        logic        st;
        logic        rd;
        logic        rdy;
        logic [63:0] tgt;
        logic [63:0] e_addr;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_count;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic rd, input logic rdy,
                                input logic [63:0] tgt, input logic [63:0] a,
                                input logic [63:0] p, input logic [31:0] ins,
                                input logic v, input logic f, input logic [31:0] c);
        vec_t r;
        r.st = st; r.rd = rd; r.rdy = rdy; r.tgt = tgt;
        r.e_addr = a; r.e_pc = p; r.e_instr = ins;
        r.e_valid = v; r.e_fault = f; r.e_count = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] a, input logic [63:0] p,
                           input logic [31:0] ins, input logic v, input logic f,
                           input logic [31:0] c);
        chk({tag, ".imem_addr"},   imem_addr, a);
        chk({tag, ".ifid_pc"},     ifid_pc, p);
        chk({tag, ".ifid_instr"},  64'(ifid_instr), 64'(ins));
        chk({tag, ".ifid_valid"},  64'(ifid_valid), 64'(v));
        chk({tag, ".fetch_fault"}, 64'(fetch_fault), 64'(f));
        chk({tag, ".fetch_count"}, 64'(fetch_count), 64'(c));
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    vec_t vecs[$];

    initial begin
        // Vectors applied starting in RUN with PC=0, IF/ID bubble, count=0
        vecs.push_back(mk(0,0,1, 64'h0,  64'h4,  64'h0,  mem_word(64'h0),  1,0,1));
        vecs.push_back(mk(0,0,1, 64'h0,  64'h8,  64'h4,  mem_word(64'h4),  1,0,2));
        vecs.push_back(mk(0,0,1, 64'h0,  64'hC,  64'h8,  mem_word(64'h8),  1,0,3));
        vecs.push_back(mk(1,0,1, 64'h0,  64'hC,  64'h8,  mem_word(64'h8),  1,0,3));
        vecs.push_back(mk(1,0,1, 64'h0,  64'hC,  64'h8,  mem_word(64'h8),  1,0,3));
        vecs.push_back(mk(0,0,1, 64'h0,  64'h10, 64'hC,  mem_word(64'hC),  1,0,4));
        vecs.push_back(mk(1,1,1, 64'h40, 64'h40, 64'hC,  NOP,              0,0,4));
        vecs.push_back(mk(0,0,1, 64'h0,  64'h44, 64'h40, mem_word(64'h40), 1,0,5));
        vecs.push_back(mk(0,1,0, 64'h10, 64'h10, 64'h40, NOP,              0,0,5));
        vecs.push_back(mk(0,0,0, 64'h0,  64'h10, 64'h40, NOP,              0,0,5));
        vecs.push_back(mk(0,0,0, 64'h0,  64'h10, 64'h40, NOP,              0,0,5));
        vecs.push_back(mk(0,0,1, 64'h0,  64'h14, 64'h10, mem_word(64'h10), 1,0,6));
        vecs.push_back(mk(1,0,0, 64'h0,  64'h14, 64'h10, mem_word(64'h10), 1,0,6));
        vecs.push_back(mk(0,1,1, TOP,    TOP,    64'h10, NOP,              0,0,6));
        vecs.push_back(mk(0,0,1, 64'h0,  64'h0,  TOP,    mem_word(TOP),    1,0,7));
        vecs.push_back(mk(0,0,1, 64'h0,  64'h4,  64'h0,  mem_word(64'h0),  1,0,8));
        // Misaligned redirect (even alongside stall) -> fault, then everything ignored
        vecs.push_back(mk(1,1,1, 64'h42, 64'h4,  64'h0,  NOP,              0,1,8));
        vecs.push_back(mk(0,1,1, 64'h80, 64'h4,  64'h0,  NOP,              0,1,8));
        vecs.push_back(mk(0,0,1, 64'h0,  64'h4,  64'h0,  NOP,              0,1,8));
        vecs.push_back(mk(0,0,1, 64'h0,  64'h4,  64'h0,  NOP,              0,1,8));

        RESET = 1'b1;
        imem_ready = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = '0;

        // Reset held for 3 cycles
        repeat (3) step();
        chk_all("reset", 64'h0, 64'h0, NOP, 0, 0, 0);

        // Release; first edge is BOOT with no fetch
        RESET = 1'b0;
        step();
        chk_all("boot", 64'h0, 64'h0, NOP, 0, 0, 0);

        foreach (vecs[i]) begin
            stall = vecs[i].st;
            redirect = vecs[i].rd;
            imem_ready = vecs[i].rdy;
            redirect_target = vecs[i].tgt;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc,
                    vecs[i].e_instr, vecs[i].e_valid, vecs[i].e_fault, vecs[i].e_count);
        end

        // Asynchronous reset while in FAULT, between clock edges
        stall = 1'b0;
        redirect = 1'b0;
        imem_ready = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        chk_all("async_rst", 64'h0, 64'h0, NOP, 0, 0, 0);
        step();
        RESET = 1'b0;
        step();
        chk_all("reboot", 64'h0, 64'h0, NOP, 0, 0, 0);
        step();
        chk_all("refetch", 64'h4, 64'h0, mem_word(64'h0), 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
